// File: rtl/mem_responder.sv
// mem_responder: single-port synchronous memory with a fixed-latency read pipeline.
// Optional power-on clear sequencer enabled by defining MEM_CLEAR_ON_RESET_EN.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chip_en,
  input  logic              read_write,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
    $error("mem_responder: RD_LAT must be 1..4");
  end
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic              wr_acc;
  logic              rd_acc;
`ifdef MEM_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we;
  // terminal compare happens before the increment, so the counter parks at all-ones
  always_comb begin
    clr_we  = state_q == CLEAR;
    cnt_d   = (clr_we && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    state_d = (clr_we && cnt_q == '1) ? READY : state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy = clr_we;
`else
  assign busy = 1'b0;
`endif
  assign wr_acc = chip_en && !busy && read_write;
  assign rd_acc = chip_en && !busy && !read_write;
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wr_acc) mem_q[address] <= data_in;
`ifdef MEM_CLEAR_ON_RESET_EN
      if (clr_we) mem_q[cnt_q] <= '0;
`endif
    end
  end
  // stage data only loads behind a valid, so the last stage holds its last response
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= mem_q[address];
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end
  assign data_out = dat_q[RD_LAT-1];
  assign rd_valid = vld_q[RD_LAT-1];
endmodule
